traffic_lamp_monitor: RTL

Passive checker on the lamp side of the 4-way traffic controller. Samples the 12 lamp lines (red/green/yellow per direction), decodes the active direction and phase, and measures the length of every phase in clock cycles. Flags illegal lamp patterns, sequence violations, short phases and stuck phases as sticky faults. Sits beside the controller in the top level and in the verification harness, fed by the same lamp nets that drive the pads.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/traffic_lamp_decode.sv | 41 ++++
 rtl/traffic_lamp_monitor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: codes shared by the 4-way traffic controller and its lamp monitor.
//   phase_e            - 2-bit phase code (RED, GREEN, YELLOW, DARK)
//   FLT_*              - bit positions inside the monitor's fault vector
//   legal_transition() - true when a phase change follows the legal lamp cycle
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_DARK   = 2'd3
  } phase_e;

  localparam int FLT_MULTI = 0;
  localparam int FLT_DARK  = 1;
  localparam int FLT_SKIP  = 2;
  localparam int FLT_SHORT = 3;
  localparam int FLT_STUCK = 4;
  localparam int FLT_W     = 5;

  // Only RED->GREEN may hand the road to another direction; the
  // GREEN->YELLOW->RED run-down must stay on the same direction.
  function automatic logic legal_transition(input phase_e     from_ph,
                                            input logic [1:0] from_dir,
                                            input phase_e     to_ph,
                                            input logic [1:0] to_dir);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      PH_RED:    ok = (to_ph == PH_GREEN);
      PH_GREEN:  ok = (to_ph == PH_YELLOW) && (to_dir == from_dir);
      PH_YELLOW: ok = (to_ph == PH_RED) && (to_dir == from_dir);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// traffic_lamp_decode: combinational decode of the 12 registered lamp lines.
//   lamp  [11:0] - {yellow[3:0], green[3:0], red[3:0]}
//   valid        - exactly one lamp lit
//   dark         - no lamp lit
//   multi        - more than one lamp lit
//   dir   [1:0]  - direction of the lit lamp (meaningful when valid)
//   phase        - phase of the lit lamp, PH_DARK when not valid
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic [11:0] lamp,
  output logic        valid,
  output logic        dark,
  output logic        multi,
  output logic [1:0]  dir,
  output phase_e      phase
);

  logic [3:0] ones;
  logic [3:0] idx;

  always_comb begin
    ones = 4'd0;
    idx  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (lamp[i]) begin
        ones = ones + 4'd1;
        idx  = i[3:0];
      end
    end
  end

  assign valid = (ones == 4'd1);
  assign dark  = (ones == 4'd0);
  assign multi = (ones > 4'd1);
  // The lamp vector is laid out as three 4-bit groups, so the bit index
  // splits directly into {phase, dir}.
  assign dir   = idx[1:0];
  assign phase = valid ? phase_e'(idx[3:2]) : PH_DARK;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: passive checker on the lamp side of the traffic controller.
// Measures every phase length and raises sticky faults on illegal lamp patterns.
//   clk, reset (async, active-high)
//   red/green/yellow [3:0] - lamp lines, bit i = direction i
//   clear                  - synchronous pulse clearing the sticky faults
//   dir, phase, phase_valid - currently tracked phase
//   phase_len, len_phase, len_valid - length/code of the phase that just ended
//   fault [4:0], irq       - sticky MULTI/DARK/SKIP/SHORT/STUCK and their OR
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 3,
  parameter int MIN_RED    = 4,
  parameter int MAX_PHASE  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       red,
  input  logic [3:0]       green,
  input  logic [3:0]       yellow,
  input  logic             clear,
  output logic [1:0]       dir,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] phase_len,
  output logic [1:0]       len_phase,
  output logic             len_valid,
  output logic [4:0]       fault,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STUCK_PRE = CNT_W'(MAX_PHASE - 1);

  logic [11:0]      lamp_q;
  logic [1:0]       cur_dir_q, cur_dir_d;
  phase_e           cur_phase_q, cur_phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_valid_q, phase_valid_d;
  logic             entered_q, entered_d;   // current phase began with a transition
  logic [CNT_W-1:0] phase_len_q, phase_len_d;
  phase_e           len_phase_q, len_phase_d;
  logic             len_valid_q, len_valid_d;
  logic [FLT_W-1:0] fault_q, fault_d;
  logic [FLT_W-1:0] flt_set;

  logic       dec_valid, dec_dark, dec_multi;
  logic [1:0] dec_dir;
  phase_e     dec_phase;

  traffic_lamp_decode u_decode (
    .lamp  (lamp_q),
    .valid (dec_valid),
    .dark  (dec_dark),
    .multi (dec_multi),
    .dir   (dec_dir),
    .phase (dec_phase)
  );

  function automatic logic [CNT_W-1:0] min_len(input phase_e ph);
    logic [CNT_W-1:0] m;
    case (ph)
      PH_GREEN:  m = CNT_W'(MIN_GREEN);
      PH_YELLOW: m = CNT_W'(MIN_YELLOW);
      PH_RED:    m = CNT_W'(MIN_RED);
      default:   m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    cur_dir_d     = cur_dir_q;
    cur_phase_d   = cur_phase_q;
    count_d       = count_q;
    phase_valid_d = phase_valid_q;
    entered_d     = entered_q;
    phase_len_d   = phase_len_q;
    len_phase_d   = len_phase_q;
    len_valid_d   = 1'b0;
    flt_set       = '0;

    if (dec_multi) begin
      flt_set[FLT_MULTI] = 1'b1;
    end else if (dec_dark) begin
      // All-dark before the first phase is just the controller coming up.
      if (phase_valid_q) flt_set[FLT_DARK] = 1'b1;
    end else if (dec_valid) begin
      if (!phase_valid_q) begin
        cur_dir_d     = dec_dir;
        cur_phase_d   = dec_phase;
        count_d       = CNT_W'(1);
        phase_valid_d = 1'b1;
        entered_d     = 1'b0;
      end else if (dec_dir == cur_dir_q && dec_phase == cur_phase_q) begin
        if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
        if (count_q == STUCK_PRE) flt_set[FLT_STUCK] = 1'b1;
      end else begin
        len_valid_d = 1'b1;
        phase_len_d = count_q;
        len_phase_d = cur_phase_q;
        // The initial phase may have been joined part-way, so it is not judged.
        if (entered_q) begin
          if (!legal_transition(cur_phase_q, cur_dir_q, dec_phase, dec_dir))
            flt_set[FLT_SKIP] = 1'b1;
          if (count_q < min_len(cur_phase_q))
            flt_set[FLT_SHORT] = 1'b1;
        end
        cur_dir_d   = dec_dir;
        cur_phase_d = dec_phase;
        count_d     = CNT_W'(1);
        entered_d   = 1'b1;
      end
    end

    // A fresh set condition beats a simultaneous clear on that bit.
    fault_d = (clear ? '0 : fault_q) | flt_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamp_q        <= '0;
      cur_dir_q     <= 2'd0;
      cur_phase_q   <= PH_DARK;
      count_q       <= '0;
      phase_valid_q <= 1'b0;
      entered_q     <= 1'b0;
      phase_len_q   <= '0;
      len_phase_q   <= PH_RED;
      len_valid_q   <= 1'b0;
      fault_q       <= '0;
    end else begin
      lamp_q        <= {yellow, green, red};
      cur_dir_q     <= cur_dir_d;
      cur_phase_q   <= cur_phase_d;
      count_q       <= count_d;
      phase_valid_q <= phase_valid_d;
      entered_q     <= entered_d;
      phase_len_q   <= phase_len_d;
      len_phase_q   <= len_phase_d;
      len_valid_q   <= len_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign dir         = cur_dir_q;
  assign phase       = cur_phase_q;
  assign phase_valid = phase_valid_q;
  assign phase_len   = phase_len_q;
  assign len_phase   = len_phase_q;
  assign len_valid   = len_valid_q;
  assign fault       = fault_q;
  assign irq         = |fault_q;

endmodule
